fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 126 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding the write port of an async FIFO.
// One requester owns the FIFO for up to MAX_BURST words per grant, with an IDLE bubble between grants.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wr_clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  input  logic                          fifo_full_i,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic                          grant_valid_o,
  output logic [2:0]                    grant_id_o,
  output logic [15:0]                   word_cnt_o
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                state, state_nxt;
  logic [GW-1:0]         grant, grant_nxt;
  logic [GW-1:0]         last_grant, last_grant_nxt;
  logic [CW-1:0]         burst_cnt, burst_cnt_nxt;
  logic [15:0]           word_cnt, word_cnt_nxt;
  logic                  req_sel;
  logic [DATA_WIDTH-1:0] data_sel;
  logic                  wr_en;

  // First requesting index strictly after the previous owner, wrapping at NUM_REQ.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [GW-1:0]      last);
    logic [GW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
    return pick;
  endfunction

  always_comb begin
    req_sel  = 1'b0;
    data_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant == GW'(k)) begin
        req_sel  = req_i[k];
        data_sel = data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Write only when the owner has a word and the FIFO has room; a full FIFO stalls the burst.
  assign wr_en = (state == BURST) && req_sel && !fifo_full_i;

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    burst_cnt_nxt  = burst_cnt;
    word_cnt_nxt   = word_cnt;
    fifo_wr_en_o   = 1'b0;
    ack_o          = '0;
    fifo_data_o    = '0;
    grant_valid_o  = 1'b0;
    grant_id_o     = '0;
    case (state)
      IDLE: begin
        if (|req_i) begin
          grant_nxt     = rr_pick(req_i, last_grant);
          burst_cnt_nxt = '0;
          state_nxt     = BURST;
        end
      end
      BURST: begin
        grant_valid_o = 1'b1;
        grant_id_o    = 3'(grant);
        fifo_data_o   = data_sel;
        fifo_wr_en_o  = wr_en;
        ack_o         = wr_en ? (NUM_REQ'(1) << grant) : '0;
        if (wr_en) begin
          burst_cnt_nxt = burst_cnt + CW'(1);
          word_cnt_nxt  = word_cnt + 16'd1;
          if (burst_cnt_nxt == CW'(MAX_BURST)) begin
            state_nxt      = IDLE;
            last_grant_nxt = grant;
          end
        end else if (!req_sel) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      burst_cnt  <= '0;
      word_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      burst_cnt  <= burst_cnt_nxt;
      word_cnt   <= word_cnt_nxt;
    end
  end

  assign word_cnt_o = word_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a transaction-level reference model.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;

  logic                          wr_clk = 1'b0;
  logic                          rst_n;
  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] data_i;
  logic                          fifo_full_i;
  logic [NUM_REQ-1:0]            ack_o;
  logic                          fifo_wr_en_o;
  logic [DATA_WIDTH-1:0]         fifo_data_o;
  logic                          grant_valid_o;
  logic [2:0]                    grant_id_o;
  logic [15:0]                   word_cnt_o;

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .wr_clk(wr_clk), .rst_n(rst_n), .req_i(req_i), .data_i(data_i),
    .fifo_full_i(fifo_full_i), .ack_o(ack_o), .fifo_wr_en_o(fifo_wr_en_o),
    .fifo_data_o(fifo_data_o), .grant_valid_o(grant_valid_o),
    .grant_id_o(grant_id_o), .word_cnt_o(word_cnt_o)
  );

  always #5 wr_clk = ~wr_clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: who owns the FIFO, how many words it may still write, totals.
  bit          m_act;
  int          m_grant, m_last, m_left;
  logic [15:0] m_words;

  function automatic int next_owner(input logic [NUM_REQ-1:0] r, input int last);
    for (int i = 1; i <= NUM_REQ; i++)
      if (r[(last + i) % NUM_REQ]) return (last + i) % NUM_REQ;
    return 0;
  endfunction

  task automatic m_reset();
    m_act = 1'b0; m_grant = 0; m_last = NUM_REQ - 1; m_left = 0; m_words = '0;
  endtask

  task automatic drive_chk(input logic [NUM_REQ-1:0] r, input logic f,
                           input logic [NUM_REQ*DATA_WIDTH-1:0] d);
    logic exp_wr;
    req_i = r; fifo_full_i = f; data_i = d;
    #1;
    exp_wr = m_act && r[m_grant] && !f;
    chk("wr_en",  fifo_wr_en_o, exp_wr);
    chk("ack",    ack_o, exp_wr ? (32'd1 << m_grant) : 32'd0);
    chk("data",   fifo_data_o, m_act ? d[m_grant*DATA_WIDTH +: DATA_WIDTH] : 0);
    chk("gvalid", grant_valid_o, m_act);
    chk("gid",    grant_id_o, m_act ? m_grant : 0);
    chk("wcnt",   word_cnt_o, m_words);
    chk("no_ovf", fifo_wr_en_o & fifo_full_i, 0);
  endtask

  task automatic adv();
    @(posedge wr_clk);
    if (!m_act) begin
      if (req_i != 0) begin
        m_grant = next_owner(req_i, m_last);
        m_act   = 1'b1;
        m_left  = MAX_BURST;
      end
    end else if (req_i[m_grant] && !fifo_full_i) begin
      m_words++;
      m_left--;
      if (m_left == 0) begin m_act = 1'b0; m_last = m_grant; end
    end else if (!req_i[m_grant]) begin
      m_act = 1'b0; m_last = m_grant;
    end
    @(negedge wr_clk);
  endtask

  task automatic step(input logic [NUM_REQ-1:0] r, input logic f,
                      input logic [NUM_REQ*DATA_WIDTH-1:0] d);
    drive_chk(r, f, d);
    adv();
  endtask

  task automatic do_reset();
    @(negedge wr_clk);
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(negedge wr_clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] gq[$];
    logic [2:0] exp_g[5];
    logic       prev_gv;
    int         cyc;

    exp_g = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    rst_n = 1'b1; req_i = '1; fifo_full_i = 1'b0; data_i = 32'h12345678;
    @(negedge wr_clk);
    rst_n = 1'b0;
    #1;
    chk("rst_wr_en", fifo_wr_en_o, 0);
    chk("rst_ack",   ack_o, 0);
    chk("rst_data",  fifo_data_o, 0);
    chk("rst_gv",    grant_valid_o, 0);
    chk("rst_gid",   grant_id_o, 0);
    chk("rst_wcnt",  word_cnt_o, 0);
    m_reset();
    repeat (2) @(negedge wr_clk);
    rst_n = 1'b1;

    // All requesters busy: strict rotation 0,1,2,3,0 with 4 words each.
    prev_gv = 1'b0;
    for (int c = 0; c < 25; c++) begin
      drive_chk(4'hF, 1'b0, $urandom);
      if (grant_valid_o && !prev_gv) gq.push_back(grant_id_o);
      prev_gv = grant_valid_o;
      if (c == 20) chk("r32_wcnt16", word_cnt_o, 16);
      adv();
    end
    chk("r32_ngrants", gq.size() >= 5, 1);
    for (int i = 0; i < 5; i++)
      chk("r32_order", (gq.size() > i) ? gq[i] : 3'h7, exp_g[i]);

    // Lone persistent requester 2 is re-granted after the bubble.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive_chk(4'b0100, 1'b0, 32'h00A50000);
      if (c == 1 || c == 6) chk("r33_gid", grant_id_o, 2);
      if (c >= 1 && c <= 4) chk("r33_data", fifo_data_o, 8'hA5);
      if (c == 5) chk("r33_bubble", grant_valid_o, 0);
      adv();
    end

    // Full stall in the middle of requester 1's burst.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      drive_chk(4'b0010, (c >= 3 && c <= 5), $urandom);
      if (c >= 3 && c <= 5) chk("r34_stall", {fifo_wr_en_o, ack_o}, 0);
      if (c == 8) chk("r34_total", word_cnt_o, 4);
      adv();
    end

    // Requester 3 drops after one word; requester 0 is next.
    do_reset();
    step(4'b1000, 1'b0, $urandom);
    step(4'b1000, 1'b0, $urandom);
    drive_chk(4'b0001, 1'b0, $urandom);
    adv();
    drive_chk(4'b0001, 1'b0, $urandom);
    chk("r35_idle", grant_valid_o, 0);
    chk("r35_wcnt", word_cnt_o, 1);
    adv();
    drive_chk(4'b0001, 1'b0, $urandom);
    chk("r35_next", grant_id_o, 0);
    adv();

    // Reset mid-burst aborts writes immediately; arbitration restarts at requester 0.
    do_reset();
    for (int c = 0; c < 3; c++) step(4'b0100, 1'b0, $urandom);
    req_i = 4'b0100;
    #1;
    chk("r36_pre", fifo_wr_en_o, 1);
    rst_n = 1'b0;
    #1;
    chk("r36_wr_en", fifo_wr_en_o, 0);
    chk("r36_ack",   ack_o, 0);
    chk("r36_wcnt",  word_cnt_o, 0);
    chk("r36_gv",    grant_valid_o, 0);
    m_reset();
    repeat (2) @(negedge wr_clk);
    rst_n = 1'b1;
    step(4'b0110, 1'b0, $urandom);
    drive_chk(4'b0110, 1'b0, $urandom);
    chk("r36_first", grant_id_o, 1);
    adv();

    // Word counter wrap.
    do_reset();
    cyc = 0;
    while (m_words != 16'hFFFF && cyc < 90000) begin
      step(4'b0001, 1'b0, $urandom);
      cyc++;
    end
    chk("r37_reach", cyc < 90000, 1);
    chk("r37_ffff", word_cnt_o, 16'hFFFF);
    cyc = 0;
    while (m_words != 16'h0000 && cyc < 10) begin
      step(4'b0001, 1'b0, $urandom);
      cyc++;
    end
    chk("r37_wrap_reach", cyc < 10, 1);
    chk("r37_wrap", word_cnt_o, 0);

    // Random requests, data and full flag.
    do_reset();
    for (int c = 0; c < 2000; c++)
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), $urandom);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
